// File: rtl/time_display_mux.sv
// Four-digit multiplexed 7-segment driver for a packed 12-hour time value.
// Each frame snapshots the time once, then scans DIG3..DIG0 from that snapshot.
module time_display_mux #(
    parameter int unsigned SCAN_TICKS = 2,
    parameter int unsigned BLANK_LEAD = 1
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [26:0] disp_time,
    input  logic        show_sec,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pm_led
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SNAP_W = 28;
    localparam logic [6:0]  GLYPH_DASH  = 7'h3F;
    localparam logic [6:0]  GLYPH_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        LATCH = 3'd0,
        DIG3  = 3'd1,
        DIG2  = 3'd2,
        DIG1  = 3'd3,
        DIG0  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SNAP_W-1:0]   r_snap;
    logic [SNAP_W-1:0]   w_src;

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        r_pm;
    logic [3:0]  w_an_nxt;
    logic [6:0]  w_seg_nxt;
    logic        w_dp_nxt;

    logic [3:0]  w_hour;
    logic [5:0]  w_min;
    logic [5:0]  w_sec;
    logic        w_pm;
    logic [9:0]  w_ms;
    logic        w_show_sec;
    logic        w_valid;
    logic [5:0]  w_left;
    logic [5:0]  w_right;
    logic [7:0]  w_left_bcd;
    logic [7:0]  w_right_bcd;
    logic [6:0]  w_glyph3;
    logic [6:0]  w_glyph2;
    logic [6:0]  w_glyph1;
    logic [6:0]  w_glyph0;

    // Binary 0..63 to {tens, units} by repeated subtraction (at most 6 steps).
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    // State and dwell counter.
    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            r_state <= LATCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if ((r_state == LATCH) || (r_cnt == CNT_W'(SCAN_TICKS - 1))) begin
            w_cnt_nxt = '0;
            case (r_state)
                LATCH:   w_state_nxt = DIG3;
                DIG3:    w_state_nxt = DIG2;
                DIG2:    w_state_nxt = DIG1;
                DIG1:    w_state_nxt = DIG0;
                default: w_state_nxt = LATCH;
            endcase
        end
    end

    // Snapshot is taken on the edge leaving LATCH; DIG3 decodes the incoming value.
    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            r_snap <= '0;
        end else if (r_state == LATCH) begin
            r_snap <= {show_sec, disp_time};
        end
    end

    assign w_src = (r_state == LATCH) ? {show_sec, disp_time} : r_snap;

    always_comb begin
        w_show_sec  = w_src[27];
        w_hour      = w_src[26:23];
        w_min       = w_src[22:17];
        w_sec       = w_src[16:11];
        w_pm        = w_src[10];
        w_ms        = w_src[9:0];
        w_valid     = (w_hour != 4'd0) && (w_hour <= 4'd12) && (w_min <= 6'd59)
                   && (w_sec <= 6'd59) && (w_ms <= 10'd999);
        w_left      = w_show_sec ? w_min : {2'b00, w_hour};
        w_right     = w_show_sec ? w_sec : w_min;
        w_left_bcd  = to_bcd(w_left);
        w_right_bcd = to_bcd(w_right);
        w_glyph3    = glyph(w_left_bcd[7:4]);
        w_glyph2    = glyph(w_left_bcd[3:0]);
        w_glyph1    = glyph(w_right_bcd[7:4]);
        w_glyph0    = glyph(w_right_bcd[3:0]);
        if ((BLANK_LEAD != 0) && (w_left_bcd[7:4] == 4'd0)) begin
            w_glyph3 = GLYPH_BLANK;
        end
        if (!w_valid) begin
            w_glyph3 = GLYPH_DASH;
            w_glyph2 = GLYPH_DASH;
            w_glyph1 = GLYPH_DASH;
            w_glyph0 = GLYPH_DASH;
        end
    end

    // Outputs are decoded for the state being entered so they line up with it.
    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = GLYPH_BLANK;
        w_dp_nxt  = 1'b1;
        case (w_state_nxt)
            DIG3: begin
                w_an_nxt  = 4'b0111;
                w_seg_nxt = w_glyph3;
            end
            DIG2: begin
                w_an_nxt  = 4'b1011;
                w_seg_nxt = w_glyph2;
                w_dp_nxt  = !(w_valid && (w_ms < 10'd500));
            end
            DIG1: begin
                w_an_nxt  = 4'b1101;
                w_seg_nxt = w_glyph1;
            end
            DIG0: begin
                w_an_nxt  = 4'b1110;
                w_seg_nxt = w_glyph0;
            end
            default: begin
                w_an_nxt  = 4'hF;
                w_seg_nxt = GLYPH_BLANK;
            end
        endcase
    end

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 4'hF;
            r_seg <= GLYPH_BLANK;
            r_dp  <= 1'b1;
            r_pm  <= 1'b0;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
            if (r_state == LATCH) begin
                r_pm <= w_valid & w_pm;
            end
        end
    end

    assign an     = r_an;
    assign seg    = r_seg;
    assign dp     = r_dp;
    assign pm_led = r_pm;

endmodule

// File: tb/tb_time_display_mux.sv
// Scoreboard bench for time_display_mux: three instances (SCAN_TICKS 2/1/3) share stimulus.
module tb_time_display_mux;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pm;
    } exp_t;

    logic        kh_clk;
    logic        reset;
    logic [26:0] disp_time;
    logic        show_sec;

    logic [3:0] an2, an1, an3;
    logic [6:0] seg2, seg1, seg3;
    logic       dp2, dp1, dp3;
    logic       pm2, pm1, pm3;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int n_checks;
    int n_errors;

    time_display_mux #(.SCAN_TICKS(2), .BLANK_LEAD(1)) dut (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .show_sec(show_sec),
        .an(an2), .seg(seg2), .dp(dp2), .pm_led(pm2)
    );

    time_display_mux #(.SCAN_TICKS(1), .BLANK_LEAD(1)) dut_st1 (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .show_sec(show_sec),
        .an(an1), .seg(seg1), .dp(dp1), .pm_led(pm1)
    );

    time_display_mux #(.SCAN_TICKS(3), .BLANK_LEAD(0)) dut_st3 (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .show_sec(show_sec),
        .an(an3), .seg(seg3), .dp(dp3), .pm_led(pm3)
    );

    initial begin
        kh_clk = 1'b0;
        forever #5 kh_clk = ~kh_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [26:0] pack_time(input int h, input int m, input int s,
                                              input int pm, input int ms);
        logic [26:0] t;
        t[26:23] = 4'(h);
        t[22:17] = 6'(m);
        t[16:11] = 6'(s);
        t[10]    = 1'(pm);
        t[9:0]   = 10'(ms);
        return t;
    endfunction

    // Pushes one full frame (DIG3..DIG0 then the LATCH blank) for instance sel.
    task automatic push_frame(input int sel, input int st, input int bl,
                              input logic [26:0] t, input logic ss);
        int h, m, s, ms, left, right;
        bit valid;
        logic pmv;
        logic [6:0] g[4];
        exp_t e;
        h  = int'(t[26:23]);
        m  = int'(t[22:17]);
        s  = int'(t[16:11]);
        ms = int'(t[9:0]);
        valid = (h >= 1) && (h <= 12) && (m <= 59) && (s <= 59) && (ms <= 999);
        left  = ss ? m : h;
        right = ss ? s : m;
        g[3] = (bl != 0 && left / 10 == 0) ? 7'h7F : ref_glyph(left / 10);
        g[2] = ref_glyph(left % 10);
        g[1] = ref_glyph(right / 10);
        g[0] = ref_glyph(right % 10);
        pmv  = valid ? t[10] : 1'b0;
        for (int k = 3; k >= 0; k--) begin
            e.an  = ~(4'b0001 << k);
            e.seg = valid ? g[k] : 7'h3F;
            e.dp  = (k == 2 && valid && ms < 500) ? 1'b0 : 1'b1;
            e.pm  = pmv;
            for (int c = 0; c < st; c++) begin
                case (sel)
                    1: q1.push_back(e);
                    3: q3.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pm: pmv};
        case (sel)
            1: q1.push_back(e);
            3: q3.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Resets all instances and releases at a negedge with new inputs applied.
    task automatic restart(input logic [26:0] t, input logic ss);
        @(negedge kh_clk);
        reset = 1'b0;
        @(negedge kh_clk);
        disp_time = t;
        show_sec  = ss;
        reset     = 1'b1;
        q1.delete();
        q2.delete();
        q3.delete();
    endtask

    task automatic test_reset();
        exp_t act;
        exp_t exp_v;
        exp_v = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pm: 1'b0};
        @(negedge kh_clk);
        reset = 1'b0;
        #1;
        act = {an2, seg2, dp2, pm2};
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL reset_st2: got %h required %h", act, exp_v);
        end
        repeat (3) @(posedge kh_clk);
        #1;
        act = {an1, seg1, dp1, pm1};
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL reset_held_st1: got %h required %h", act, exp_v);
        end
        act = {an3, seg3, dp3, pm3};
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL reset_held_st3: got %h required %h", act, exp_v);
        end
    endtask

    // hh:mm at 09:05, colon on (ms<500), plus 12:59:07 PM in mm:ss with colon off.
    task automatic test_display();
        exp_t act;
        exp_t e;
        logic [26:0] t_a;
        logic [26:0] t_b;
        int n;
        t_a = pack_time(9, 5, 33, 0, 100);
        t_b = pack_time(12, 59, 7, 1, 600);
        restart(t_a, 1'b0);
        push_frame(2, 2, 1, t_a, 1'b0);
        push_frame(2, 2, 1, t_b, 1'b1);
        push_frame(2, 2, 1, t_b, 1'b1);
        n = q2.size();
        for (int i = 0; i < n; i++) begin
            @(negedge kh_clk);
            if (i == 8) begin
                disp_time = t_b;
                show_sec  = 1'b1;
            end
            e   = q2.pop_front();
            act = {an2, seg2, dp2, pm2};
            n_checks++;
            if (act !== e) begin
                n_errors++;
                $display("FAIL display[%0d]: got %h required %h", i, act, e);
            end
        end
    endtask

    // Input changes during DIG1 must not disturb the frame in progress.
    task automatic test_no_tear();
        exp_t act;
        exp_t e;
        logic [26:0] t_a;
        logic [26:0] t_b;
        int n;
        t_a = pack_time(12, 59, 0, 1, 200);
        t_b = pack_time(1, 0, 0, 0, 200);
        restart(t_a, 1'b0);
        push_frame(2, 2, 1, t_a, 1'b0);
        push_frame(2, 2, 1, t_b, 1'b0);
        n = q2.size();
        for (int i = 0; i < n; i++) begin
            @(negedge kh_clk);
            if (i == 4) disp_time = t_b;
            e   = q2.pop_front();
            act = {an2, seg2, dp2, pm2};
            n_checks++;
            if (act !== e) begin
                n_errors++;
                $display("FAIL no_tear[%0d]: got %h required %h", i, act, e);
            end
        end
    endtask

    // Hour 13, then minute 60 (both dashes, pm forced 0), then a valid time again.
    task automatic test_invalid();
        exp_t act;
        exp_t e;
        logic [26:0] t_a;
        logic [26:0] t_b;
        logic [26:0] t_c;
        int n;
        t_a = pack_time(13, 10, 0, 1, 100);
        t_b = pack_time(5, 60, 0, 1, 100);
        t_c = pack_time(3, 4, 0, 1, 100);
        restart(t_a, 1'b0);
        push_frame(2, 2, 1, t_a, 1'b0);
        push_frame(2, 2, 1, t_b, 1'b0);
        push_frame(2, 2, 1, t_c, 1'b0);
        n = q2.size();
        for (int i = 0; i < n; i++) begin
            @(negedge kh_clk);
            if (i == 8)  disp_time = t_b;
            if (i == 17) disp_time = t_c;
            e   = q2.pop_front();
            act = {an2, seg2, dp2, pm2};
            n_checks++;
            if (act !== e) begin
                n_errors++;
                $display("FAIL invalid[%0d]: got %h required %h", i, act, e);
            end
        end
    endtask

    // SCAN_TICKS=1 gives 5-cycle frames, SCAN_TICKS=3 gives 13-cycle frames.
    task automatic test_scan_ticks();
        exp_t act;
        exp_t e;
        logic [26:0] t_a;
        t_a = pack_time(7, 42, 18, 1, 999);
        restart(t_a, 1'b0);
        for (int f = 0; f < 3; f++) push_frame(1, 1, 1, t_a, 1'b0);
        push_frame(3, 3, 0, t_a, 1'b0);
        push_frame(3, 3, 0, t_a, 1'b0);
        for (int i = 0; i < 26; i++) begin
            @(negedge kh_clk);
            if (q1.size() > 0) begin
                e   = q1.pop_front();
                act = {an1, seg1, dp1, pm1};
                n_checks++;
                if (act !== e) begin
                    n_errors++;
                    $display("FAIL scan_st1[%0d]: got %h required %h", i, act, e);
                end
            end
            e   = q3.pop_front();
            act = {an3, seg3, dp3, pm3};
            n_checks++;
            if (act !== e) begin
                n_errors++;
                $display("FAIL scan_st3[%0d]: got %h required %h", i, act, e);
            end
        end
    endtask

    // Reset during DIG1 blanks outputs at once; the next frame uses the new snapshot.
    task automatic test_reset_mid();
        exp_t act;
        exp_t e;
        exp_t rst_v;
        logic [26:0] t_a;
        logic [26:0] t_b;
        int n;
        rst_v = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pm: 1'b0};
        t_a = pack_time(11, 23, 0, 1, 50);
        t_b = pack_time(10, 8, 0, 0, 450);
        restart(t_a, 1'b0);
        push_frame(2, 2, 1, t_a, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge kh_clk);
            e   = q2.pop_front();
            act = {an2, seg2, dp2, pm2};
            n_checks++;
            if (act !== e) begin
                n_errors++;
                $display("FAIL pre_reset[%0d]: got %h required %h", i, act, e);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        act = {an2, seg2, dp2, pm2};
        n_checks++;
        if (act !== rst_v) begin
            n_errors++;
            $display("FAIL reset_mid_async: got %h required %h", act, rst_v);
        end
        disp_time = t_b;
        q2.delete();
        @(negedge kh_clk);
        reset = 1'b1;
        push_frame(2, 2, 1, t_b, 1'b0);
        n = q2.size();
        for (int i = 0; i < n; i++) begin
            @(negedge kh_clk);
            e   = q2.pop_front();
            act = {an2, seg2, dp2, pm2};
            n_checks++;
            if (act !== e) begin
                n_errors++;
                $display("FAIL post_reset[%0d]: got %h required %h", i, act, e);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        disp_time = '0;
        show_sec  = 1'b0;
        test_reset();
        test_display();
        test_no_tear();
        test_invalid();
        test_scan_ticks();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
